// File: rtl/counter_modn_cascade_en.sv
// -----------------------------------------------------------------------------
// counter_modn_cascade_en
//
// Multi-digit modulo-MOD counter with count enable, synchronous load and
// up/down direction. DIGITS digits of W bits are cascaded, with digit 0 the
// least significant. Typical uses are BCD displays, 0-59 timers and pixel/line
// sub-counters.
//
// Every digit counts modulo the same modulus, which must lie between 2 and
// 2**W inclusive; W sets the bit width of one digit and DIGITS sets how many
// digits are chained.
//
// Ports:
//   clk         rising-edge clock
//   i_sclr      synchronous active-high clear (highest priority)
//   i_en        count enable, one step per enabled cycle
//   i_dn        direction: 0 = up, 1 = down
//   i_load      synchronous load of i_load_val (ignores i_en)
//   i_load_val  load value, digit k at [k*W +: W]; digits >= MOD load as 0
//   o_cnt       registered count, digit k at [k*W +: W]
//   o_tc        combinational terminal count, chain into the next i_en
//   o_wrap      registered one-cycle pulse after the counter wraps
//
// Build option:
//   COUNTER_SATURATE_EN  when defined, the counter holds at its terminal value
//                        instead of wrapping and o_wrap stays 0.
// -----------------------------------------------------------------------------
module counter_modn_cascade_en #(
  parameter int MOD    = 10,
  parameter int W      = 4,
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  i_sclr,
  input  logic                  i_en,
  input  logic                  i_dn,
  input  logic                  i_load,
  input  logic [DIGITS*W-1:0]   i_load_val,
  output logic [DIGITS*W-1:0]   o_cnt,
  output logic                  o_tc,
  output logic                  o_wrap
);

  localparam logic [W-1:0] DIG_MAX = W'(MOD - 1);
  localparam logic [W-1:0] DIG_ONE = W'(1);
  localparam logic [W-1:0] DIG_ZERO = {W{1'b0}};
  // One extra bit so that MOD == 2**W is still representable.
  localparam logic [W:0]   MOD_EXT = (W + 1)'(MOD);

  if ((MOD < 2) || (MOD > (2 ** W))) begin : g_bad_mod
    $error("counter_modn_cascade_en: MOD=%0d out of range for W=%0d", MOD, W);
  end

  logic [DIGITS*W-1:0] cnt_r;
  logic                wrap_r;

  logic [DIGITS-1:0]   at_max_s;
  logic [DIGITS-1:0]   at_zero_s;
  logic [DIGITS-1:0]   step_s;
  logic                term_s;
  logic [DIGITS*W-1:0] cnt_step_s;
  logic [DIGITS*W-1:0] cnt_nxt_s;
  logic [DIGITS*W-1:0] load_val_s;

  // Per-digit flags: digit sits at its top value or at zero.
  always_comb begin
    at_max_s  = {DIGITS{1'b0}};
    at_zero_s = {DIGITS{1'b0}};
    for (int k = 0; k < DIGITS; k++) begin
      at_max_s[k]  = (cnt_r[k*W +: W] == DIG_MAX);
      at_zero_s[k] = (cnt_r[k*W +: W] == DIG_ZERO);
    end
  end

  // Ripple enable: a digit steps when every lower digit is at its roll-over
  // value for the current direction. The full chain is the terminal flag.
  always_comb begin
    logic all_term;
    all_term = 1'b1;
    step_s   = {DIGITS{1'b0}};
    for (int k = 0; k < DIGITS; k++) begin
      step_s[k] = i_en & all_term;
      if (i_dn) begin
        all_term = all_term & at_zero_s[k];
      end else begin
        all_term = all_term & at_max_s[k];
      end
    end
    term_s = all_term;
  end

  // Terminal count is zero-latency so a following instance can use it as i_en.
  always_comb begin
    o_tc = i_en & ~i_load & ~i_sclr & term_s;
  end

  // Per-digit increment/decrement with modulo roll-over.
  always_comb begin
    cnt_step_s = cnt_r;
    for (int k = 0; k < DIGITS; k++) begin
      if (step_s[k]) begin
        if (i_dn) begin
          if (at_zero_s[k]) begin
            cnt_step_s[k*W +: W] = DIG_MAX;
          end else begin
            cnt_step_s[k*W +: W] = cnt_r[k*W +: W] - DIG_ONE;
          end
        end else begin
          if (at_max_s[k]) begin
            cnt_step_s[k*W +: W] = DIG_ZERO;
          end else begin
            cnt_step_s[k*W +: W] = cnt_r[k*W +: W] + DIG_ONE;
          end
        end
      end else begin
        cnt_step_s[k*W +: W] = cnt_r[k*W +: W];
      end
    end
  end

  // Enabled next value: wrap normally, or hold at terminal when saturating.
  always_comb begin
    cnt_nxt_s = cnt_step_s;
`ifdef COUNTER_SATURATE_EN
    if (term_s) begin
      cnt_nxt_s = cnt_r;
    end else begin
      cnt_nxt_s = cnt_step_s;
    end
`endif
  end

  // Load value with out-of-range digits forced to zero.
  always_comb begin
    load_val_s = {(DIGITS*W){1'b0}};
    for (int k = 0; k < DIGITS; k++) begin
      if ({1'b0, i_load_val[k*W +: W]} < MOD_EXT) begin
        load_val_s[k*W +: W] = i_load_val[k*W +: W];
      end else begin
        load_val_s[k*W +: W] = DIG_ZERO;
      end
    end
  end

  // Count and wrap-pulse registers; priority clear > load > enable.
  always_ff @(posedge clk) begin
    if (i_sclr) begin
      cnt_r  <= {(DIGITS*W){1'b0}};
      wrap_r <= 1'b0;
    end else if (i_load) begin
      cnt_r  <= load_val_s;
      wrap_r <= 1'b0;
    end else if (i_en) begin
      cnt_r  <= cnt_nxt_s;
`ifdef COUNTER_SATURATE_EN
      wrap_r <= 1'b0;
`else
      // Enabled, no clear/load: term_s here is exactly o_tc.
      wrap_r <= term_s;
`endif
    end else begin
      cnt_r  <= cnt_r;
      wrap_r <= 1'b0;
    end
  end

  assign o_cnt  = cnt_r;
  assign o_wrap = wrap_r;

endmodule

// File: tb/tb_counter_modn_cascade_en.sv
// -----------------------------------------------------------------------------
// tb_counter_modn_cascade_en
//
// Bench for counter_modn_cascade_en with MOD=10, W=4, DIGITS=2. A table of
// directed vectors, hand-written terminal/wrap sequences, then random stimulus
// against an integer-valued reference model.
// -----------------------------------------------------------------------------
module tb_counter_modn_cascade_en;

  localparam int MOD    = 10;
  localparam int W      = 4;
  localparam int DIGITS = 2;
  localparam int N      = DIGITS * W;
  localparam int TOTAL  = MOD ** DIGITS;
`ifdef COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk;
  logic         i_sclr;
  logic         i_en;
  logic         i_dn;
  logic         i_load;
  logic [N-1:0] i_load_val;
  logic [N-1:0] o_cnt;
  logic         o_tc;
  logic         o_wrap;

  int checks;
  int errors;

  counter_modn_cascade_en #(.MOD(MOD), .W(W), .DIGITS(DIGITS)) dut (
    .clk        (clk),
    .i_sclr     (i_sclr),
    .i_en       (i_en),
    .i_dn       (i_dn),
    .i_load     (i_load),
    .i_load_val (i_load_val),
    .o_cnt      (o_cnt),
    .o_tc       (o_tc),
    .o_wrap     (o_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         sclr;
    logic         load;
    logic         en;
    logic         dn;
    logic [N-1:0] lv;
    logic         tc;    // expected o_tc before the edge
    logic [N-1:0] cnt;   // expected o_cnt after the edge
    logic         wrap;  // expected o_wrap after the edge
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic s, input logic l, input logic e, input logic d,
                       input logic [N-1:0] lv);
    i_sclr = s; i_load = l; i_en = e; i_dn = d; i_load_val = lv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the count as a plain integer 0..TOTAL-1.
  int m_val;
  bit m_wrap;

  function automatic int load_to_int(input logic [N-1:0] lv);
    int v, mul, d;
    v = 0; mul = 1;
    for (int k = 0; k < DIGITS; k++) begin
      d = int'(lv[k*W +: W]);
      if (d >= MOD) d = 0;
      v += d * mul;
      mul *= MOD;
    end
    return v;
  endfunction

  function automatic logic [N-1:0] int_to_cnt(input int v);
    logic [N-1:0] r;
    int rem;
    r = '0; rem = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[k*W +: W] = W'(rem % MOD);
      rem = rem / MOD;
    end
    return r;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    apply(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // sclr, load, en, dn, load_val, tc, cnt, wrap
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h47, 1'b0, 8'h47, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h48, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h49, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h50, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h49, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h5A, 1'b0, 8'h50, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h50, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h50, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h50, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h50, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h50, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h99, 1'b0, 8'h99, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h99, 1'b0, 8'h00, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h99, 1'b0, 8'h99, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h23, 1'b0, 8'h23, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'hA9, 1'b0, 8'h09, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 8'h08, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 8'h00, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0};

    foreach (vecs[i]) begin
      apply(vecs[i].sclr, vecs[i].load, vecs[i].en, vecs[i].dn, vecs[i].lv);
      #3;
      check($sformatf("vec%0d_tc", i), 32'(o_tc), 32'(vecs[i].tc));
      tick();
      check($sformatf("vec%0d_cnt", i), 32'(o_cnt), 32'(vecs[i].cnt));
      check($sformatf("vec%0d_wrap", i), 32'(o_wrap), 32'(vecs[i].wrap));
    end

    // Count up from reset to the terminal value, then across it.
    apply(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    check("up_reset_wrap", 32'(o_wrap), 32'd0);
    apply(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 99; i++) begin
      tick();
    end
    #3;
    check("up_cnt_99", 32'(o_cnt), 32'h99);
    check("up_tc", 32'(o_tc), 32'd1);
    check("up_wrap_pre", 32'(o_wrap), 32'd0);
    tick();
    check("up_cnt_after", 32'(o_cnt), SAT ? 32'h99 : 32'h00);
    check("up_wrap_pulse", 32'(o_wrap), SAT ? 32'd0 : 32'd1);
    apply(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    check("up_wrap_drop", 32'(o_wrap), 32'd0);

    // Count down from reset: immediate terminal count.
    apply(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    apply(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    #3;
    check("dn_tc", 32'(o_tc), 32'd1);
    tick();
    check("dn_cnt_99", 32'(o_cnt), SAT ? 32'h00 : 32'h99);
    check("dn_wrap", 32'(o_wrap), SAT ? 32'd0 : 32'd1);
    #3;
    check("dn_tc_off", 32'(o_tc), SAT ? 32'd1 : 32'd0);
    tick();
    check("dn_cnt_98", 32'(o_cnt), SAT ? 32'h00 : 32'h98);
    check("dn_wrap_drop", 32'(o_wrap), 32'd0);

    // Load with enable at 99 must not pulse wrap; tc is masked by load.
    apply(1'b0, 1'b1, 1'b0, 1'b0, 8'h99);
    tick();
    apply(1'b0, 1'b1, 1'b1, 1'b0, 8'h12);
    #3;
    check("ld99_tc", 32'(o_tc), 32'd0);
    tick();
    check("ld99_cnt", 32'(o_cnt), 32'h12);
    check("ld99_wrap", 32'(o_wrap), 32'd0);

    // Random stimulus against the integer model.
    apply(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    m_val  = 0;
    m_wrap = 1'b0;
    for (int i = 0; i < 600; i++) begin
      logic s, l, e, d, m_tc, term;
      logic [N-1:0] lv;
      s = ($urandom_range(0, 39) == 0);
      l = ($urandom_range(0, 15) == 0);
      e = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 2) == 0) ? ~i_dn : i_dn;
      case ($urandom_range(0, 3))
        0:       lv = 8'h99;
        1:       lv = 8'h00;
        default: lv = N'($urandom);
      endcase
      apply(s, l, e, d, lv);
      #3;
      term = d ? (m_val == 0) : (m_val == TOTAL - 1);
      m_tc = e & ~l & ~s & term;
      check("rnd_tc", 32'(o_tc), 32'(m_tc));
      tick();
      if (s) begin
        m_val = 0; m_wrap = 1'b0;
      end else if (l) begin
        m_val = load_to_int(lv); m_wrap = 1'b0;
      end else if (e) begin
        if (SAT && term) begin
          m_wrap = 1'b0;
        end else begin
          m_val  = d ? (m_val + TOTAL - 1) % TOTAL : (m_val + 1) % TOTAL;
          m_wrap = m_tc;
        end
      end else begin
        m_wrap = 1'b0;
      end
      check("rnd_cnt", 32'(o_cnt), 32'(int_to_cnt(m_val)));
      check("rnd_wrap", 32'(o_wrap), 32'(m_wrap));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
